// File: rtl/fp8_seg_scroller.sv
// fp8_seg_scroller: scrolls the fields of an FP8 E5M2 word over one 7-seg digit.
// Optional FP8_SEG_ACTIVE_LOW_EN inverts every glyph for common-anode boards.
module fp8_seg_scroller #(
  parameter int DWELL = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] value_in,
  output logic [7:0] seg_out,
  output logic [2:0] phase
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

`ifdef FP8_SEG_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SIGN   = 3'd1,
    EXP_HI = 3'd2,
    EXP_LO = 3'd3,
    MAN    = 3'd4,
    SPEC   = 3'd5,
    GAP    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    word_q, word_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    glyph;
  logic          special;

  function automatic logic [7:0] hex7(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'h0: g = 8'h3F;
      4'h1: g = 8'h06;
      4'h2: g = 8'h5B;
      4'h3: g = 8'h4F;
      4'h4: g = 8'h66;
      4'h5: g = 8'h6D;
      4'h6: g = 8'h7D;
      4'h7: g = 8'h07;
      4'h8: g = 8'h7F;
      4'h9: g = 8'h6F;
      4'hA: g = 8'h77;
      4'hB: g = 8'h7C;
      4'hC: g = 8'h39;
      4'hD: g = 8'h5E;
      4'hE: g = 8'h79;
      default: g = 8'h71;
    endcase
    return g;
  endfunction

  assign special = (word_q[6:2] == 5'h1F);

  // Next state: load restarts at SIGN, otherwise advance after DWELL enabled cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    if (load) begin
      word_d  = value_in;
      cnt_d   = '0;
      state_d = SIGN;
    end else if (ena && state_q != IDLE) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        unique case (state_q)
          SIGN:    state_d = special ? SPEC : EXP_HI;
          EXP_HI:  state_d = EXP_LO;
          EXP_LO:  state_d = MAN;
          MAN:     state_d = GAP;
          SPEC:    state_d = GAP;
          GAP:     state_d = SIGN;
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Glyph for the state being entered, so seg_out stays a pure register
  always_comb begin
    glyph = 8'h00;
    unique case (state_d)
      SIGN:    glyph = word_d[7] ? 8'h40 : 8'h00;
      EXP_HI:  glyph = hex7({3'b000, word_d[6]});
      EXP_LO:  glyph = hex7(word_d[5:2]);
      MAN:     glyph = hex7({2'b00, word_d[1:0]}) | 8'h80;
      SPEC:    glyph = (word_d[1:0] == 2'b00) ? 8'h76 : 8'h54;
      default: glyph = 8'h00;
    endcase
    seg_d = glyph ^ POL;
  end

  // State, counter, captured word and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= 8'h00;
      seg_q   <= POL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_out = seg_q;
  assign phase   = state_q;

endmodule

// File: doc/fp8_seg_scroller.md
# fp8_seg_scroller

Sequential display driver for the E5M2 FP8 (1 sign, 5 exponent, 2 mantissa bits) results produced by the adder datapath. It captures one 8-bit FP8 word and scrolls its fields across the single 7-segment digit on `uo_out`, one glyph per dwell period, repeating until a new word is loaded. It sits between the adder result and the output pins, so a human can read results on the board.

## Interface
Parameters:
- `DWELL`, default 1_000_000: number of enabled clock cycles each glyph is held. Legal range is at least 1. The counter width is `$clog2(DWELL)`, with a minimum of 1.

Ports:
- `clk`  input  1  clock.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `ena`  input  1  when low, the dwell counter and FSM freeze and the outputs hold.
- `load`  input  1  single-cycle capture strobe; sampled on any cycle, regardless of `ena`.
- `value_in`  input  8  FP8 E5M2 word {s, e[4:0], m[1:0]}.
- `seg_out`  output  8  glyph {dp,g,f,e,d,c,b,a}; active-high by default.
- `phase`  output  3  current FSM state encoding, for debug and bench.

## Operation
- The word is classified at capture:
  - special: e == 31. Infinity when m == 0, NaN otherwise.
  - all other words (zero, subnormal, normal) are numeric.
- FSM states and encodings: IDLE=0, SIGN=1, EXP_HI=2, EXP_LO=3, MAN=4, SPEC=5, GAP=6.
- Numeric sequence: SIGN → EXP_HI → EXP_LO → MAN → GAP → SIGN, repeating.
- Special sequence: SIGN → SPEC → GAP → SIGN, repeating.
- Glyph per state:
  - SIGN: `-` (0x40) if s=1, blank (0x00) if s=0.
  - EXP_HI: hex digit of e[4] (0 or 1).
  - EXP_LO: hex digit of e[3:0].
  - MAN: hex digit of m, with dp set.
  - SPEC: `H` (0x76) for infinity, `n` (0x54) for NaN.
  - GAP: blank (0x00).
  - IDLE: blank (0x00).
- Hex glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- `seg_out` and `phase` are registered outputs. There is no combinational path from inputs to outputs.

## Timing
- Reset: state IDLE, `seg_out`=0x00, `phase`=0, dwell counter 0, captured word 0x00.
- Leaving IDLE: only `load` leaves IDLE.
- Load latency: `load` high at edge N captures `value_in` and clears the counter. At edge N+1, state=SIGN and `seg_out` shows the SIGN glyph for the new word.
- Load mid-scroll: aborts the current sequence immediately, with the same one-cycle latency. No glyph of the old word appears after edge N.
- Back-to-back loads: the last one wins. The sequence restarts from the last load.
- Dwell: each non-IDLE state is held for exactly DWELL enabled cycles.
  - The counter increments on each cycle with `ena`=1.
  - When it reaches DWELL-1 with `ena`=1, it wraps to 0 and the FSM advances on that edge.
  - With DWELL=1, the FSM advances every enabled cycle.
- `ena`=0: the counter, state and outputs hold.
  - `load` still captures and restarts to SIGN.
  - After that restart, the counter stays at 0 until `ena` returns.
- Async reset mid-sequence: all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- `FP8_SEG_ACTIVE_LOW_EN`: when defined, `seg_out` is the bitwise inverse of every glyph above, for common-anode boards.
  - The reset value becomes 0xFF, and blank is 0xFF.
  - `phase` and all timing are unchanged.
- When the macro is undefined, the output is active-high as specified above.

## Test plan
All scenarios run with DWELL=4 and `ena`=1 unless stated otherwise.
- Reset, then 20 cycles with no `load` → `seg_out`=0x00 and `phase`=0 throughout.
- Load 0x3C (+1.0) → glyphs 0x00, 0x3F, 0x71, 0xBF, 0x00, each held 4 cycles; the sequence then repeats starting from 0x00 at SIGN.
- Load 0xC1 (s=1, e=16, m=1) → glyphs 0x40, 0x06, 0x3F, 0x86, 0x00.
- Load 0x7C (+inf) → glyphs 0x00, 0x76, 0x00, repeating. Load 0xFE (NaN) → glyphs 0x40, 0x54, 0x00.
- Load 0x3C, then load 0xC1 on the 2nd cycle of EXP_LO → 0x40 appears on the next cycle, `phase`=1, held 4 cycles. Separately, drop `ena` for 10 cycles mid-MAN → the glyph holds for 4 enabled cycles in total.
- Assert `rst_n`=0 mid-sequence → `seg_out` goes to 0x00 before the next edge. With `FP8_SEG_ACTIVE_LOW_EN` defined, rerun the 0x3C case → glyphs 0xFF, 0xC0, 0x8E, 0x40, 0xFF.
